// File: rtl/rf_pkg.sv
// Shared constants, types and write-port arbitration for the multi-ported register file.
package rf_pkg;

  localparam int unsigned RfDataW = 16;
  localparam int unsigned RfAddrW = 6;
  localparam int unsigned RfNumRd = 2;
  localparam int unsigned RfNumWr = 2;
  localparam int unsigned RfMaxWr = 4;

  typedef logic [RfAddrW-1:0] rf_addr_t;
  typedef logic [RfDataW-1:0] rf_data_t;

  // Winning write port for one register; valid=0 when no port targets it.
  typedef struct packed {
    logic       valid;
    logic [1:0] port;
  } rf_wr_sel_t;

  // hit[p] set when write port p targets the register; highest-numbered port wins.
  function automatic rf_wr_sel_t rf_wr_arbitrate(input logic [RfMaxWr-1:0] hit);
    rf_wr_sel_t sel;
    sel = '0;
    for (int p = 0; p < RfMaxWr; p++) begin
      if (hit[p]) begin
        sel.valid = 1'b1;
        sel.port  = 2'(p);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// Decode/writeback bundle of the register file; master = datapath, slave = register file.
interface rf_multiport_if
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RfDataW,
  parameter int unsigned ADDR_W = RfAddrW,
  parameter int unsigned NUM_RD = RfNumRd,
  parameter int unsigned NUM_WR = RfNumWr
) ();

  logic [NUM_RD-1:0]             re;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_busy;

  logic [NUM_WR-1:0]             we;
  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0] wr_data;

  logic                          rsv_en;
  logic [ADDR_W-1:0]             rsv_addr;

  logic                          wr_conflict;

  modport master (
    output re, rd_addr, we, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, wr_conflict
  );

  modport slave (
    input  re, rd_addr, we, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, wr_conflict
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: writes clear, reserves set; reports busy per read address
// both before and after this cycle's update.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = RfAddrW,
  parameter int unsigned NUM_RD = RfNumRd,
  parameter int unsigned NUM_WR = RfNumWr
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_WR-1:0]             we_i,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr_i,
  input  logic                          rsv_en_i,
  input  logic [ADDR_W-1:0]             rsv_addr_i,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]             busy_pre_o,
  output logic [NUM_RD-1:0]             busy_post_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [Depth-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (we_i[p] && (wr_addr_i[p] != '0)) begin
        busy_d[wr_addr_i[p]] = 1'b0;
      end
    end
    // Reserve applied last: it belongs to a newer producer than any retiring write.
    if (rsv_en_i && (rsv_addr_i != '0)) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    busy_pre_o  = '0;
    busy_post_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      busy_pre_o[i]  = busy_q[rd_addr_i[i]];
      busy_post_o[i] = busy_d[rd_addr_i[i]];
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Multi-ported register file with registered reads, hardwired-zero r0 and write conflict flag.
// Define RF_BYPASS_EN for write-first reads; default build is read-first.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RfDataW,
  parameter int unsigned ADDR_W = RfAddrW,
  parameter int unsigned NUM_RD = RfNumRd,
  parameter int unsigned NUM_WR = RfNumWr
) (
  input logic           clk,
  input logic           rst_n,
  rf_multiport_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

`ifdef RF_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] mem_d [Depth];

  logic [NUM_RD-1:0][DATA_W-1:0] rd_val;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data_q;
  logic [NUM_RD-1:0]             rd_busy_q;
  logic [NUM_RD-1:0]             busy_pre, busy_post, busy_sel;
  logic                          conflict_d, wr_conflict_q;

  // Next array state; entry 0 is never a write target so it stays at its reset value.
  always_comb begin
    mem_d = mem_q;
    for (int a = 1; a < Depth; a++) begin
      logic [RfMaxWr-1:0] hit;
      rf_wr_sel_t         sel;
      hit = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        hit[p] = bus.we[p] && (bus.wr_addr[p] == ADDR_W'(a));
      end
      sel = rf_wr_arbitrate(hit);
      if (sel.valid) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (sel.port == 2'(p)) begin
            mem_d[a] = bus.wr_data[p];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      for (int q = p + 1; q < NUM_WR; q++) begin
        if (bus.we[p] && bus.we[q] && (bus.wr_addr[p] == bus.wr_addr[q]) &&
            (bus.wr_addr[p] != '0)) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .we_i        (bus.we),
    .wr_addr_i   (bus.wr_addr),
    .rsv_en_i    (bus.rsv_en),
    .rsv_addr_i  (bus.rsv_addr),
    .rd_addr_i   (bus.rd_addr),
    .busy_pre_o  (busy_pre),
    .busy_post_o (busy_post)
  );

  // Write-first sees this edge's winning write and scoreboard update; read-first sees old state.
  always_comb begin
    rd_val   = '0;
    busy_sel = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_val[i]   = Bypass ? mem_d[bus.rd_addr[i]] : mem_q[bus.rd_addr[i]];
      busy_sel[i] = Bypass ? busy_post[i] : busy_pre[i];
      if (bus.rd_addr[i] == '0) begin
        rd_val[i]   = '0;
        busy_sel[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q     <= '0;
      rd_busy_q     <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (bus.re[i]) begin
          rd_data_q[i] <= rd_val[i];
          rd_busy_q[i] <= busy_sel[i];
        end
      end
      wr_conflict_q <= conflict_d;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_busy     = rd_busy_q;
  assign bus.wr_conflict = wr_conflict_q;

endmodule
